ex_muldiv: RTL and testbench
============================

# ex_muldiv

Iterative multiply/divide unit for the execute stage. It consumes the operands and M-extension operation that the ID/EX pipeline register presents to EX, and computes one result bit per cycle. While it works it holds the pipeline with a stall request. It returns the 32-bit result in the cycle the stall drops, so the EX/MEM register captures it on the same edge.

## Interface
Parameters:
- XLEN, riscv_pkg::XLEN (32): operand and result width; the iteration count equals XLEN.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- req  input  1  level; EX holds a valid M-extension instruction (IDEX_valid & ctrl_e.mdu_en)
- op  input  3  riscv_pkg::mdu_op_e (funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
- a  input  XLEN  rs1 operand (post-forwarding)
- b  input  XLEN  rs2 operand (post-forwarding)
- kill  input  1  abort the in-flight operation (EX flush)
- stall  output  1  pipeline hold request to the hazard unit
- result_valid  output  1  result is valid this cycle
- result  output  XLEN  product, quotient or remainder

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE to RUN: on req & ~kill.
  - Latch the op.
  - Latch the operand magnitudes; signed ops take the absolute value.
  - Latch the result sign: op-dependent sign of a/b.
  - Load cnt = XLEN-1.
- Division special cases in IDLE go directly to DONE, with no RUN cycles:
  - b == 0: quotient = all ones, remainder = a.
  - Signed overflow (a = 0x8000_0000, b = all ones): quotient = 0x8000_0000, remainder = 0.
- RUN, multiply: shift-add over a 2*XLEN accumulator, one multiplier bit per cycle.
- RUN, divide: restoring division, one quotient bit per cycle.
- RUN transitions:
  - cnt decrements each RUN cycle.
  - At cnt == 0, go to DONE.
  - kill in RUN goes to IDLE on the next edge and discards the partial state.
- DONE:
  - Apply the sign fix-up and select the result.
  - MUL: low XLEN bits of the product.
  - MULH/MULHSU/MULHU: high XLEN bits of the product.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder, which takes the sign of the dividend.
  - Assert result_valid; always return to IDLE on the next edge.
- req is ignored in DONE (it is the same instruction). A new req is accepted in the following IDLE cycle.
- stall = (IDLE & req & ~kill) | RUN. It is low in DONE, so the pipeline advances on the DONE edge.
- kill in DONE: result_valid is forced low; the next state is still IDLE.

## Timing
- Reset: state = IDLE, cnt = 0, all datapath registers = 0, stall = 0, result_valid = 0, result = 0.
- Reset is asynchronous: asserting it mid-RUN forces IDLE immediately, with no result produced.
- Normal op latency: accept edge at cycle 0, RUN for cycles 1..XLEN, DONE at cycle XLEN+1. stall is high for cycles 0..XLEN, so XLEN+1 stall cycles in total.
- Special-case division: stall is high for cycle 0 only; DONE at cycle 1.
- result and result_valid are registered outputs, valid only in DONE. In all other states result holds 0.
- stall is combinational from req/kill in IDLE. Otherwise it decodes from the state register.
- Back-to-back M-ops: there is exactly one idle cycle between DONE and the next accept, and it is the cycle the next instruction sits in EX.

## Structure
- riscv_pkg additions:
  - mdu_op_e enum, 3-bit, with encoding equal to funct3.
  - mdu_state_e enum (IDLE, RUN, DONE).
  - ctrl_s field mdu_en.
- No sub-module. The counter, accumulator and sign fix-up are inline.
- State and datapath registers use async active-low reset flops.
- Integration: stall is ORed into the hazard unit's StallF/StallD/StallE.

## Test plan
- MUL a=7, b=6 -> stall high 33 cycles, then result_valid with result=42 (0x2A).
- MULH a=0xFFFF_FFFF, b=0xFFFF_FFFF -> result=0. MULHU with the same operands -> result=0xFFFF_FFFE.
- DIV a=-7, b=2 -> result=0xFFFF_FFFD (-3). REM with the same operands -> result=0xFFFF_FFFF (-1).
- DIVU a=5, b=0 -> 1 stall cycle, result=0xFFFF_FFFF. REM a=0x8000_0000, b=0xFFFF_FFFF -> result=0.
- kill asserted in RUN cycle 10 -> IDLE on the next edge, stall low, no result_valid. A subsequent MUL 3*3 -> result=9.
- rst pulsed low mid-RUN -> all outputs 0 immediately. After release, DIVU 100/7 -> result=14, REMU -> result=2.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core types: M-extension op encoding, multiply/divide FSM states,
// and the decode control bundle carried into EX.
package riscv_pkg;

    localparam int XLEN = 32;

    // Encoding equals funct3 of the M-extension instructions
    typedef enum logic [2:0] {
        MDU_MUL    = 3'b000,
        MDU_MULH   = 3'b001,
        MDU_MULHSU = 3'b010,
        MDU_MULHU  = 3'b011,
        MDU_DIV    = 3'b100,
        MDU_DIVU   = 3'b101,
        MDU_REM    = 3'b110,
        MDU_REMU   = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_RUN  = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    typedef struct packed {
        logic reg_we;
        logic mem_re;
        logic mem_we;
        logic mdu_en;
    } ctrl_s;

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit: one product/quotient bit per cycle, stalling the
// pipeline while busy and presenting the result in the cycle the stall drops.
module ex_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req,
    input  mdu_op_e         op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            stall,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);

    mdu_state_e        r_state, w_state_next;
    logic [CW-1:0]     r_cnt, w_cnt_next;
    mdu_op_e           r_op, w_op_next;
    logic [2*XLEN-1:0] r_acc, w_acc_next;
    logic [XLEN-1:0]   r_opnd, w_opnd_next;
    logic              r_neg, w_neg_next;
    logic [XLEN-1:0]   r_result, w_result_next;
    logic              r_valid, w_valid_next;

    logic              w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic              w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0]   w_spec_result;

    assign w_is_div   = op[2];
    assign w_a_signed = w_is_div ? ~op[0] : (op != MDU_MULHU);
    assign w_b_signed = w_is_div ? ~op[0] : ~op[1];
    assign w_a_neg    = w_a_signed & a[XLEN-1];
    assign w_b_neg    = w_b_signed & b[XLEN-1];
    assign w_a_mag    = w_a_neg ? (~a + 1'b1) : a;
    assign w_b_mag    = w_b_neg ? (~b + 1'b1) : b;

    // Zero divisor and signed overflow resolve without iterating
    assign w_div_zero    = (b == '0);
    assign w_div_ovf     = ~op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (&b);
    assign w_special     = w_is_div & (w_div_zero | w_div_ovf);
    assign w_spec_result = w_div_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // Shift-add step: the multiplier sits in the low half and shifts out LSB first
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_acc;
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring step: partial remainder in the high half, quotient shifts into the low half
    logic [XLEN:0]     w_rem_sh;
    logic              w_ge;
    logic [XLEN-1:0]   w_sub;
    logic [2*XLEN-1:0] w_div_acc;
    assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    assign w_ge      = (w_rem_sh >= {1'b0, r_opnd});
    assign w_sub     = w_rem_sh[XLEN-1:0] - r_opnd;
    assign w_div_acc = {(w_ge ? w_sub : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

    logic [2*XLEN-1:0] w_step, w_prod_fix;
    logic [XLEN-1:0]   w_quot_fix, w_rem_fix, w_final;
    assign w_step     = r_op[2] ? w_div_acc : w_mul_acc;
    assign w_prod_fix = r_neg ? (~w_step + 1'b1) : w_step;
    assign w_quot_fix = r_neg ? (~w_step[XLEN-1:0] + 1'b1) : w_step[XLEN-1:0];
    assign w_rem_fix  = r_neg ? (~w_step[2*XLEN-1:XLEN] + 1'b1) : w_step[2*XLEN-1:XLEN];

    always_comb begin
        case (r_op)
            MDU_MUL:                        w_final = w_prod_fix[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:              w_final = w_quot_fix;
            default:                        w_final = w_rem_fix;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_op_next     = r_op;
        w_acc_next    = r_acc;
        w_opnd_next   = r_opnd;
        w_neg_next    = r_neg;
        w_result_next = '0;
        w_valid_next  = 1'b0;
        stall         = 1'b0;
        case (r_state)
            MDU_IDLE: begin
                if (req && !kill) begin
                    stall      = 1'b1;
                    w_op_next  = op;
                    w_neg_next = (w_is_div && op[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
                    if (w_special) begin
                        w_state_next  = MDU_DONE;
                        w_result_next = w_spec_result;
                        w_valid_next  = 1'b1;
                    end else begin
                        w_state_next = MDU_RUN;
                        w_cnt_next   = CW'(XLEN-1);
                        w_acc_next   = {{XLEN{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        w_opnd_next  = w_is_div ? w_b_mag : w_a_mag;
                    end
                end
            end
            MDU_RUN: begin
                stall = 1'b1;
                if (kill) begin
                    w_state_next = MDU_IDLE;
                    w_cnt_next   = '0;
                    w_op_next    = MDU_MUL;
                    w_acc_next   = '0;
                    w_opnd_next  = '0;
                    w_neg_next   = 1'b0;
                end else begin
                    w_acc_next = w_step;
                    w_cnt_next = r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        w_state_next  = MDU_DONE;
                        w_cnt_next    = '0;
                        w_result_next = w_final;
                        w_valid_next  = 1'b1;
                    end
                end
            end
            MDU_DONE: w_state_next = MDU_IDLE;
            default:  w_state_next = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= MDU_IDLE;
            r_cnt    <= '0;
            r_op     <= MDU_MUL;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_neg    <= 1'b0;
            r_result <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_op     <= w_op_next;
            r_acc    <= w_acc_next;
            r_opnd   <= w_opnd_next;
            r_neg    <= w_neg_next;
            r_result <= w_result_next;
            r_valid  <= w_valid_next;
        end
    end

    assign result_valid = r_valid & ~kill;
    assign result       = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized scoreboard bench for ex_muldiv: the driver queues expected results from
// an arithmetic reference model, and a monitor compares whenever result_valid rises.
module tb_ex_muldiv;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        kill = 1'b0;
    mdu_op_e     op = MDU_MUL;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall;
    logic        result_valid;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;

    typedef struct {
        mdu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } txn_t;
    txn_t sb_q[$];

    ex_muldiv #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .req(req), .op(op), .a(a), .b(b), .kill(kill),
        .stall(stall), .result_valid(result_valid), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_model(mdu_op_e o, logic [31:0] x, logic [31:0] y);
        int          sx = signed'(x);
        int          sy = signed'(y);
        longint      px = sx;
        longint      py = sy;
        longint      uy = longint'({32'b0, y});
        logic [63:0] ux = {32'b0, x};
        logic [63:0] p;
        logic        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        int          q;
        case (o)
            MDU_MUL:    begin p = px * py; return p[31:0]; end
            MDU_MULH:   begin p = px * py; return p[63:32]; end
            MDU_MULHSU: begin p = px * uy; return p[63:32]; end
            MDU_MULHU:  begin p = ux * {32'b0, y}; return p[63:32]; end
            MDU_DIV:    begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (ovf) return x;
                q = sx / sy; return q;
            end
            MDU_DIVU:   return (y == 0) ? 32'hFFFF_FFFF : x / y;
            MDU_REM:    begin
                if (y == 0) return x;
                if (ovf) return 32'h0;
                q = sx % sy; return q;
            end
            default:    return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int exp_stalls(mdu_op_e o, logic [31:0] x, logic [31:0] y);
        logic is_div = (o == MDU_DIV) || (o == MDU_DIVU) || (o == MDU_REM) || (o == MDU_REMU);
        logic signed_div = (o == MDU_DIV) || (o == MDU_REM);
        if (is_div && (y == 0 || (signed_div && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Monitor: pops the oldest expectation on every valid result
    always @(negedge clk) begin
        txn_t t;
        if (rst && result_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid got=%h want=no_result", result);
            end else begin
                t = sb_q.pop_front();
                if (result !== t.exp) begin
                    failures++;
                    $display("FAIL result op=%s a=%h b=%h got=%h want=%h",
                             t.op.name(), t.a, t.b, result, t.exp);
                end else begin
                    $display("txn op=%-6s a=%h b=%h result=%h ok", t.op.name(), t.a, t.b, result);
                end
            end
        end else if (rst && !kill) begin
            checks++;
            if (result !== 32'h0) begin
                failures++;
                $display("FAIL result_idle_zero got=%h want=00000000", result);
            end
        end
    end

    task automatic do_op(input mdu_op_e o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want);
        txn_t t;
        int   n = 0;
        bit   done = 0;
        @(posedge clk); #1;
        op = o; a = x; b = y; req = 1'b1;
        t.op = o; t.a = x; t.b = y; t.exp = want;
        sb_q.push_back(t);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (stall) n++;
            else begin done = 1; break; end
        end
        checks++;
        if (!done || n != exp_stalls(o, x, y)) begin
            failures++;
            $display("FAIL stall_count op=%s got=%0d want=%0d done=%0d", o.name(), n,
                     exp_stalls(o, x, y), done);
        end
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    initial begin
        #12;
        check("reset_stall", {31'b0, stall}, 32'h0);
        check("reset_valid", {31'b0, result_valid}, 32'h0);
        check("reset_result", result, 32'h0);
        @(posedge clk); #1 rst = 1'b1;

        do_op(MDU_MUL,    32'd7,         32'd6,         32'h0000_002A);
        do_op(MDU_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op(MDU_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        do_op(MDU_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
        do_op(MDU_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
        do_op(MDU_DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF);
        do_op(MDU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        do_op(MDU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_op(MDU_MULHSU, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // kill in RUN cycle 10: no result, idle on the next edge
        @(posedge clk); #1;
        op = MDU_MUL; a = 32'd1234; b = 32'd5678; req = 1'b1;
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        check("stall_run_killed", {31'b0, stall}, 32'h1);
        @(posedge clk); #1;
        kill = 1'b0; req = 1'b0;
        check("stall_after_kill", {31'b0, stall}, 32'h0);
        repeat (3) @(posedge clk);
        do_op(MDU_MUL, 32'd3, 32'd3, 32'd9);

        // kill with req in IDLE: not accepted, no stall
        @(posedge clk); #1;
        op = MDU_DIV; a = 32'd50; b = 32'd5; req = 1'b1; kill = 1'b1;
        #1 check("stall_idle_kill", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        check("stall_idle_kill2", {31'b0, stall}, 32'h0);
        kill = 1'b0; req = 1'b0;

        // kill in DONE suppresses result_valid
        @(posedge clk); #1;
        op = MDU_DIVU; a = 32'd5; b = 32'd0; req = 1'b1;
        @(posedge clk); #1 kill = 1'b1;
        #1 check("valid_done_killed", {31'b0, result_valid}, 32'h0);
        check("stall_done", {31'b0, stall}, 32'h0);
        @(posedge clk); #1;
        kill = 1'b0; req = 1'b0;

        // asynchronous reset mid-RUN
        @(posedge clk); #1;
        op = MDU_MUL; a = 32'hDEAD_BEEF; b = 32'h1234_5678; req = 1'b1;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1 req = 1'b0;
        #1;
        check("arst_stall", {31'b0, stall}, 32'h0);
        check("arst_valid", {31'b0, result_valid}, 32'h0);
        check("arst_result", result, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        do_op(MDU_DIVU, 32'd100, 32'd7, 32'd14);
        do_op(MDU_REMU, 32'd100, 32'd7, 32'd2);

        for (int i = 0; i < 40; i++) begin
            mdu_op_e     o = mdu_op_e'(3'($urandom_range(0, 7)));
            logic [31:0] x = $urandom;
            logic [31:0] y = $urandom;
            case ($urandom_range(0, 5))
                0: y = 32'h0;
                1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
                2: begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
                3: begin x = -$urandom_range(0, 300); y = $urandom_range(1, 20); end
                default: ;
            endcase
            do_op(o, x, y, ref_model(o, x, y));
        end

        repeat (5) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
